// File: rtl/shape_label_scroller_pkg.sv
// Shared types, character codes and the label ROM for the shape-label scroller.
// Character codes feed seg7; code 31 is a blank digit.
package shape_disp_pkg;

    localparam int ROM_CLASSES = 3;
    localparam int ROM_MAX_LEN = 8;

    typedef logic [4:0] char_t;
    typedef logic [1:0] rom_id_t;
    typedef logic [2:0] rom_idx_t;
    typedef logic [3:0] rom_len_t;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_STATIC,
        DISP_SCROLL
    } disp_state_e;

    localparam char_t CH_BLANK = 5'd31;
    localparam char_t CH_A     = 5'd10;
    localparam char_t CH_C     = 5'd12;
    localparam char_t CH_E     = 5'd14;
    localparam char_t CH_I     = 5'd1;
    localparam char_t CH_L     = 5'd17;
    localparam char_t CH_G     = 5'd25;
    localparam char_t CH_N     = 5'd23;
    localparam char_t CH_Q     = 5'd19;
    localparam char_t CH_R     = 5'd16;
    localparam char_t CH_S     = 5'd20;
    localparam char_t CH_T     = 5'd22;
    localparam char_t CH_U     = 5'd24;

    localparam char_t LABEL_ROM [ROM_CLASSES][ROM_MAX_LEN] = '{
        '{CH_C, CH_I, CH_R, CH_C, CH_L, CH_E, CH_BLANK, CH_BLANK},
        '{CH_S, CH_Q, CH_U, CH_A, CH_R, CH_E, CH_BLANK, CH_BLANK},
        '{CH_T, CH_R, CH_I, CH_A, CH_N, CH_G, CH_L,     CH_E}
    };

    function automatic rom_len_t label_len(rom_id_t id);
        rom_len_t len;
        case (id)
            2'd0:    len = 4'd6;
            2'd1:    len = 4'd6;
            2'd2:    len = 4'd8;
            default: len = 4'd0;
        endcase
        return len;
    endfunction

    function automatic char_t label_char(rom_id_t id, rom_idx_t idx);
        char_t c;
        c = CH_BLANK;
        if (id < 2'(ROM_CLASSES)) c = LABEL_ROM[id][idx];
        return c;
    endfunction

endpackage

// File: rtl/seg7.sv
// Character code to active-low seven-segment pattern (bit 0 = segment a, bit 6 = g).
module seg7
    import shape_disp_pkg::*;
(
    input  char_t      code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (code_i)
            5'd0:    seg_o = 7'h40;
            5'd1:    seg_o = 7'h79;
            5'd2:    seg_o = 7'h24;
            5'd3:    seg_o = 7'h30;
            5'd4:    seg_o = 7'h19;
            5'd5:    seg_o = 7'h12;
            5'd6:    seg_o = 7'h02;
            5'd7:    seg_o = 7'h78;
            5'd8:    seg_o = 7'h00;
            5'd9:    seg_o = 7'h10;
            5'd10:   seg_o = 7'h08;  // A
            5'd11:   seg_o = 7'h03;  // b
            5'd12:   seg_o = 7'h46;  // C
            5'd13:   seg_o = 7'h21;  // d
            5'd14:   seg_o = 7'h06;  // E
            5'd15:   seg_o = 7'h0E;  // F
            5'd16:   seg_o = 7'h2F;  // r
            5'd17:   seg_o = 7'h47;  // L
            5'd18:   seg_o = 7'h09;  // H
            5'd19:   seg_o = 7'h18;  // q
            5'd20:   seg_o = 7'h12;  // S
            5'd21:   seg_o = 7'h0C;  // P
            5'd22:   seg_o = 7'h07;  // t
            5'd23:   seg_o = 7'h2B;  // n
            5'd24:   seg_o = 7'h41;  // U
            5'd25:   seg_o = 7'h10;  // g
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/shape_label_scroller_label_window.sv
// Selects the character codes visible on each digit for the accepted label and
// scroll position; short labels are left-justified, long ones wrap with a blank gap.
module label_window
    import shape_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int ID_W       = 2,
    parameter int POS_W      = 4,
    parameter int GAP        = 2
) (
    input  logic [ID_W-1:0]             shown_id_i,
    input  logic [POS_W-1:0]            pos_i,
    input  logic                        label_valid_i,
    output char_t [NUM_DIGITS-1:0]      chars_o
);

    rom_id_t rom_id;
    int      len;
    int      wrap;
    int      idx;

    always_comb begin
        rom_id  = rom_id_t'(shown_id_i);
        len     = int'(label_len(rom_id));
        wrap    = len + GAP;
        idx     = 0;
        chars_o = '{default: CH_BLANK};
        for (int j = 0; j < NUM_DIGITS; j++) begin
            idx = j;
            // pos < wrap and j < len, so one conditional subtract is enough
            if (len > NUM_DIGITS) begin
                idx = int'(pos_i) + j;
                if (idx >= wrap) idx = idx - wrap;
            end
            if (label_valid_i && idx < len)
                chars_o[NUM_DIGITS-1-j] = label_char(rom_id, rom_idx_t'(idx));
        end
    end

endmodule

// File: rtl/shape_label_scroller.sv
// Stability-filtered shape label display: accepts a detect class after it has been
// steady for STABLE_CYCLES edges and shows its label, scrolling when too long.
module shape_label_scroller
    import shape_disp_pkg::*;
#(
    parameter int NUM_CLASSES   = 3,
    parameter int NUM_DIGITS    = 6,
    parameter int MAX_LEN       = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int SCROLL_DIV    = 25_000_000,
    parameter int GAP           = 2,
    localparam int ID_W   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int POS_W  = (MAX_LEN + GAP > 1) ? $clog2(MAX_LEN + GAP) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CLASSES-1:0]      detect,
    input  logic                        freeze,
    output logic                        label_valid,
    output logic [ID_W-1:0]             shown_id,
    output logic [NUM_DIGITS-1:0][6:0]  hex
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int TICK_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic              lv_q, lv_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              prev_valid_q, prev_valid_d;
    logic [ID_W-1:0]   prev_id_q, prev_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [POS_W-1:0]  pos_q, pos_d;

    logic              cand_valid;
    logic [ID_W-1:0]   cand_id;
    logic              stable;
    logic              differs;
    logic              accept;
    rom_len_t          cur_len;
    disp_state_e       disp_state;
    char_t [NUM_DIGITS-1:0] chars;

    // Lowest set bit wins; NONE is encoded as valid=0, id=0
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (detect[i]) begin
                cand_valid = 1'b1;
                cand_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        cur_len    = label_len(rom_id_t'(id_q));
        disp_state = DISP_IDLE;
        if (lv_q)
            disp_state = (int'(cur_len) > NUM_DIGITS) ? DISP_SCROLL : DISP_STATIC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lv_q         <= 1'b0;
            id_q         <= '0;
            prev_valid_q <= 1'b0;
            prev_id_q    <= '0;
            cnt_q        <= '0;
            tick_q       <= '0;
            pos_q        <= '0;
        end else begin
            lv_q         <= lv_d;
            id_q         <= id_d;
            prev_valid_q <= prev_valid_d;
            prev_id_q    <= prev_id_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            pos_q        <= pos_d;
        end
    end

    always_comb begin
        lv_d         = lv_q;
        id_d         = id_q;
        prev_valid_d = prev_valid_q;
        prev_id_d    = prev_id_q;
        cnt_d        = cnt_q;
        tick_d       = tick_q;
        pos_d        = pos_q;
        stable       = 1'b0;

        if ({cand_valid, cand_id} != {prev_valid_q, prev_id_q}) begin
            prev_valid_d = cand_valid;
            prev_id_d    = cand_id;
            cnt_d        = CNT_W'(1);
            stable       = (STABLE_CYCLES == 1);
        end else begin
            if (cnt_q < CNT_W'(STABLE_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
            stable = (cnt_q >= CNT_W'(STABLE_CYCLES - 1));
        end

        differs = cand_valid ? (!lv_q || id_q != cand_id) : lv_q;
        accept  = stable && differs;

        if (accept) begin
            lv_d   = cand_valid;
            id_d   = cand_valid ? cand_id : '0;
            pos_d  = '0;
            tick_d = '0;
        end else if (disp_state == DISP_SCROLL && !freeze) begin
            if (tick_q == TICK_W'(SCROLL_DIV - 1)) begin
                tick_d = '0;
                pos_d  = (pos_q == POS_W'(int'(cur_len) + GAP - 1)) ? '0 : pos_q + POS_W'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_comb begin
        label_valid = lv_q;
        shown_id    = id_q;
    end

    label_window #(
        .NUM_DIGITS (NUM_DIGITS),
        .ID_W       (ID_W),
        .POS_W      (POS_W),
        .GAP        (GAP)
    ) u_window (
        .shown_id_i    (id_q),
        .pos_i         (pos_q),
        .label_valid_i (lv_q),
        .chars_o       (chars)
    );

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7 u_seg7 (
            .code_i (chars[g]),
            .seg_o  (hex[g])
        );
    end

endmodule

// File: tb/tb_shape_label_scroller.sv
// Bench for shape_label_scroller with STABLE_CYCLES=4, SCROLL_DIV=4.
// Expected {label_valid, shown_id, hex} words are queued per edge and compared on output.
module tb_shape_label_scroller;

    localparam int EW = 45;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       detect = 3'b000;
    logic             freeze = 1'b0;
    logic             label_valid;
    logic [1:0]       shown_id;
    logic [5:0][6:0]  hex;

    int checks   = 0;
    int failures = 0;
    int k_run    = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs, exp_v;

    localparam int ROM [3][8] = '{
        '{12, 1, 16, 12, 17, 14, 31, 31},
        '{20, 19, 24, 10, 16, 14, 31, 31},
        '{22, 16, 1, 10, 23, 25, 17, 14}
    };
    localparam int LEN [3] = '{6, 6, 8};

    shape_label_scroller #(
        .STABLE_CYCLES (4),
        .SCROLL_DIV    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .detect      (detect),
        .freeze      (freeze),
        .label_valid (label_valid),
        .shown_id    (shown_id),
        .hex         (hex)
    );

    always #5 clk = ~clk;

    // Segment pattern built from the list of lit segments
    function automatic logic [6:0] seg_pat(int code);
        string s;
        logic [6:0] p;
        case (code)
            1:  s = "bc";
            10: s = "abcefg";
            12: s = "adef";
            14: s = "adefg";
            16: s = "eg";
            17: s = "def";
            19: s = "abcfg";
            20: s = "acdfg";
            22: s = "defg";
            23: s = "ceg";
            24: s = "bcdef";
            25: s = "abcdfg";
            default: s = "";
        endcase
        p = 7'h7F;
        for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 97] = 1'b0;
        return p;
    endfunction

    function automatic logic [41:0] model_hex(bit lv, int id, int pos);
        logic [41:0] h;
        int code, idx, len;
        h = '1;
        for (int j = 0; j < 6; j++) begin
            code = 31;
            if (lv) begin
                len = LEN[id];
                idx = (len <= 6) ? j : (pos + j) % (len + 2);
                if (idx < len) code = ROM[id][idx];
            end
            h[(5 - j) * 7 +: 7] = seg_pat(code);
        end
        return h;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(bit lv, int id, int pos);
        exp_q.push_back({lv, id[1:0], model_hex(lv, id, pos)});
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        detect = 3'b100;
        step();
        step();
        push_exp(0, 0, 0);
        obs = {label_valid, shown_id, hex}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_hold got=%h expected=%h", obs, exp_v);
        end
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (n < 3) push_exp(0, 0, 0); else push_exp(1, 2, 0);
            obs = {label_valid, shown_id, hex}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL release_accept edge=%0d got=%h expected=%h", n + 1, obs, exp_v);
            end
        end
        reset = 1'b1;
        step();
        push_exp(0, 0, 0);
        obs = {label_valid, shown_id, hex}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_mid_display got=%h expected=%h", obs, exp_v);
        end
        reset  = 1'b0;
        detect = 3'b000;
        step();
    endtask

    task automatic test_glitch();
        for (int n = 0; n < 6; n++) begin
            detect = (n < 3) ? 3'b001 : 3'b000;
            step();
            push_exp(0, 0, 0);
            obs = {label_valid, shown_id, hex}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL glitch_reject edge=%0d got=%h expected=%h", n + 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_static();
        detect = 3'b001;
        for (int n = 0; n < 18; n++) begin
            if (n == 10) begin
                detect = 3'b011;
                freeze = 1'b1;
            end
            step();
            if (n < 3) push_exp(0, 0, 0); else push_exp(1, 0, 0);
            obs = {label_valid, shown_id, hex}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL static_circle edge=%0d got=%h expected=%h", n + 1, obs, exp_v);
            end
        end
        freeze = 1'b0;
    endtask

    task automatic test_scroll();
        detect = 3'b100;
        for (int n = 0; n < 4; n++) begin
            step();
            if (n < 3) push_exp(1, 0, 0); else push_exp(1, 2, 0);
            obs = {label_valid, shown_id, hex}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL switch_to_triangle edge=%0d got=%h expected=%h", n + 1, obs, exp_v);
            end
        end
        k_run = 0;
        for (int n = 0; n < 44; n++) begin
            step();
            k_run++;
            push_exp(1, 2, (k_run / 4) % 10);
            obs = {label_valid, shown_id, hex}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL scroll_step k=%0d got=%h expected=%h", k_run, obs, exp_v);
            end
        end
    endtask

    task automatic test_freeze();
        for (int n = 0; n < 22; n++) begin
            freeze = (n >= 2 && n < 14);
            step();
            if (!freeze) k_run++;
            push_exp(1, 2, (k_run / 4) % 10);
            obs = {label_valid, shown_id, hex}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL freeze_hold edge=%0d freeze=%0b got=%h expected=%h", n + 1, freeze, obs, exp_v);
            end
        end
        freeze = 1'b0;
    endtask

    task automatic test_clear();
        logic [2:0] pat [10] = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b000,
                                 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        for (int n = 0; n < 10; n++) begin
            detect = pat[n];
            step();
            if (n < 7) begin
                k_run++;
                push_exp(1, 2, (k_run / 4) % 10);
            end else begin
                push_exp(0, 0, 0);
            end
            obs = {label_valid, shown_id, hex}; exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL clear_to_idle edge=%0d got=%h expected=%h", n + 1, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_static();
        test_scroll();
        test_freeze();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
